// File: rtl/nv_ram_rwsp_4x64_fifo_ctrl_pkg.sv
// Shared constants for the 4x64 RAM FIFO controller and its output buffer.
package nv_ram_rwsp_4x64_fifo_ctrl_pkg;

    localparam int FIFO_WIDTH = 64;
    localparam int RAM_DEPTH  = 4;
    localparam int RAM_AW     = 2;
    localparam int OUT_DEPTH  = 3;
    localparam int OUT_PW     = 2;
    localparam int CNT_W      = 3;

    // Occupancy thresholds in counter width.
    localparam logic [CNT_W-1:0] RAM_FULL_CNT = 3'd4;
    localparam logic [CNT_W-1:0] OUT_FULL_CNT = 3'd3;

    // Advance an output-buffer pointer modulo OUT_DEPTH (3 entries).
    function automatic logic [OUT_PW-1:0] obuf_ptr_inc(input logic [OUT_PW-1:0] ptr);
        logic [OUT_PW-1:0] nxt;
        case (ptr)
            2'd0:    nxt = 2'd1;
            2'd1:    nxt = 2'd2;
            2'd2:    nxt = 2'd0;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/nv_ram_fifo_obuf.sv
// Three-entry circular output buffer: push at tail, pop from head, head is
// presented combinationally from registers so it holds while not popped.
module nv_ram_fifo_obuf
    import nv_ram_rwsp_4x64_fifo_ctrl_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [WIDTH-1:0]  push_data,
    input  logic              pop,
    output logic [WIDTH-1:0]  head_data,
    output logic [OUT_PW-1:0] count
);

    logic [WIDTH-1:0]  mem_r [OUT_DEPTH];
    logic [OUT_PW-1:0] wr_ptr_r;
    logic [OUT_PW-1:0] rd_ptr_r;
    logic [OUT_PW-1:0] cnt_r;

    // Storage, pointers and occupancy; the caller's credit rule prevents overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            cnt_r    <= 2'd0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= obuf_ptr_inc(wr_ptr_r);
            end
            if (pop) begin
                rd_ptr_r <= obuf_ptr_inc(rd_ptr_r);
            end
            cnt_r <= cnt_r + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign count     = cnt_r;

endmodule

// File: rtl/nv_ram_rwsp_4x64_fifo_ctrl.sv
// Valid/ready FIFO controller in front of the 4x64 registered-read RAM.
// Writes go into the RAM; reads are issued (re, then ore) only when the
// output buffer has credit for the word, so the consumer sees 1 word/cycle.
// Optional macro NV_RAM_FIFO_CTRL_BYPASS_EN: a write into a completely empty
// RAM/pipeline goes straight to the output buffer (1-cycle latency).
module nv_ram_rwsp_4x64_fifo_ctrl
    import nv_ram_rwsp_4x64_fifo_ctrl_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rstn,
    input  logic              wr_pvld,
    output logic              wr_prdy,
    input  logic [WIDTH-1:0]  wr_pd,
    output logic              rd_pvld,
    input  logic              rd_prdy,
    output logic [WIDTH-1:0]  rd_pd,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_wa,
    output logic [WIDTH-1:0]  ram_di,
    output logic              ram_re,
    output logic [RAM_AW-1:0] ram_ra,
    output logic              ram_ore,
    input  logic [WIDTH-1:0]  ram_dout,
    input  logic [31:0]       pwrbus_ram_pd,
    output logic [31:0]       ram_pwrbus_ram_pd,
    output logic [CNT_W-1:0]  fifo_count
);

    logic [RAM_AW-1:0] wr_adr_r;
    logic [RAM_AW-1:0] rd_adr_r;
    logic [CNT_W-1:0]  ram_cnt_r;
    logic              p1_r;
    logic              p2_r;

    logic [OUT_PW-1:0] out_cnt_s;
    logic [WIDTH-1:0]  head_s;
    logic              wr_prdy_s;
    logic              wr_acc_s;
    logic              pop_s;
    logic [CNT_W-1:0]  inflight_s;
    logic              issue_s;
    logic              bypass_s;
    logic              ram_we_s;
    logic              obuf_push_s;
    logic [WIDTH-1:0]  obuf_din_s;

    // Handshakes, read-issue credit, optional bypass and buffer push selection.
    always_comb begin
        wr_prdy_s   = (ram_cnt_r < RAM_FULL_CNT);
        wr_acc_s    = wr_pvld & wr_prdy_s;
        pop_s       = (out_cnt_s != 2'd0) & rd_prdy;
        // Words already committed to the buffer after this cycle's pop.
        inflight_s  = {1'b0, out_cnt_s} + {2'b00, p1_r} + {2'b00, p2_r} - {2'b00, pop_s};
        issue_s     = (ram_cnt_r != 3'd0) && (inflight_s < OUT_FULL_CNT);
`ifdef NV_RAM_FIFO_CTRL_BYPASS_EN
        // Only with RAM and read pipeline empty, so ordering cannot break.
        bypass_s    = wr_acc_s && (ram_cnt_r == 3'd0) && !p1_r && !p2_r &&
                      (({1'b0, out_cnt_s} - {2'b00, pop_s}) < OUT_FULL_CNT);
`else
        bypass_s    = 1'b0;
`endif
        ram_we_s    = wr_acc_s & ~bypass_s;
        obuf_push_s = p2_r | bypass_s;
        if (p2_r) begin
            obuf_din_s = ram_dout;
        end else begin
            obuf_din_s = wr_pd;
        end
    end

    // Address pointers, RAM occupancy and the two-stage read pipeline.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_adr_r  <= 2'd0;
            rd_adr_r  <= 2'd0;
            ram_cnt_r <= 3'd0;
            p1_r      <= 1'b0;
            p2_r      <= 1'b0;
        end else begin
            if (ram_we_s) begin
                wr_adr_r <= wr_adr_r + 2'd1;
            end
            if (issue_s) begin
                rd_adr_r <= rd_adr_r + 2'd1;
            end
            ram_cnt_r <= ram_cnt_r + {2'b00, ram_we_s} - {2'b00, issue_s};
            p1_r      <= issue_s;
            p2_r      <= p1_r;
        end
    end

    nv_ram_fifo_obuf #(
        .WIDTH (WIDTH)
    ) u_obuf (
        .clk       (nvdla_core_clk),
        .rst_n     (nvdla_core_rstn),
        .push      (obuf_push_s),
        .push_data (obuf_din_s),
        .pop       (pop_s),
        .head_data (head_s),
        .count     (out_cnt_s)
    );

    assign wr_prdy           = wr_prdy_s;
    assign ram_we            = ram_we_s;
    assign ram_wa            = wr_adr_r;
    assign ram_di            = wr_pd;
    assign ram_re            = issue_s;
    assign ram_ra            = rd_adr_r;
    assign ram_ore           = p1_r;
    assign rd_pvld           = (out_cnt_s != 2'd0);
    assign rd_pd             = head_s;
    assign ram_pwrbus_ram_pd = pwrbus_ram_pd;
    assign fifo_count        = ram_cnt_r + {2'b00, p1_r} + {2'b00, p2_r} + {1'b0, out_cnt_s};

endmodule

// File: tb/tb_nv_ram_rwsp_4x64_fifo_ctrl.sv
// Scoreboard bench for nv_ram_rwsp_4x64_fifo_ctrl with a behavioural model of
// the 4x64 registered-read RAM. Accepted writes push expectations; a monitor
// pops and compares on every consumer handshake.
module tb_nv_ram_rwsp_4x64_fifo_ctrl;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr_pvld;
    logic         wr_prdy;
    logic [W-1:0] wr_pd;
    logic         rd_pvld;
    logic         rd_prdy;
    logic [W-1:0] rd_pd;
    logic         ram_we;
    logic [1:0]   ram_wa;
    logic [W-1:0] ram_di;
    logic         ram_re;
    logic [1:0]   ram_ra;
    logic         ram_ore;
    logic [W-1:0] ram_dout;
    logic [31:0]  pwrbus;
    logic [31:0]  ram_pwrbus;
    logic [2:0]   fifo_count;

    always #5 clk = ~clk;

    nv_ram_rwsp_4x64_fifo_ctrl dut (
        .nvdla_core_clk    (clk),
        .nvdla_core_rstn   (rst_n),
        .wr_pvld           (wr_pvld),
        .wr_prdy           (wr_prdy),
        .wr_pd             (wr_pd),
        .rd_pvld           (rd_pvld),
        .rd_prdy           (rd_prdy),
        .rd_pd             (rd_pd),
        .ram_we            (ram_we),
        .ram_wa            (ram_wa),
        .ram_di            (ram_di),
        .ram_re            (ram_re),
        .ram_ra            (ram_ra),
        .ram_ore           (ram_ore),
        .ram_dout          (ram_dout),
        .pwrbus_ram_pd     (pwrbus),
        .ram_pwrbus_ram_pd (ram_pwrbus),
        .fifo_count        (fifo_count)
    );

    // RAM model: re latches the address, ore loads the output register.
    logic [W-1:0] ram_mem [4];
    logic [1:0]   ram_ra_d;
    logic [W-1:0] ram_q;
    always @(posedge clk) begin
        if (ram_we)  ram_mem[ram_wa] <= ram_di;
        if (ram_re)  ram_ra_d <= ram_ra;
        if (ram_ore) ram_q <= ram_mem[ram_ra_d];
    end
    assign ram_dout = ram_q;

    // Independent bookkeeping of RAM occupancy, addresses and re history.
    int         tb_ram_cnt;
    logic [1:0] tb_wa;
    logic [1:0] tb_ra;
    logic       prev_re;
    int         cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tb_ram_cnt <= 0;
            tb_wa      <= 2'd0;
            tb_ra      <= 2'd0;
            prev_re    <= 1'b0;
        end else begin
            tb_ram_cnt <= tb_ram_cnt + int'(ram_we) - int'(ram_re);
            if (ram_we) tb_wa <= tb_wa + 2'd1;
            if (ram_re) tb_ra <= tb_ra + 2'd1;
            prev_re <= ram_re;
        end
    end

    int           n_cmp = 0;
    int           n_bad = 0;
    int           n_pop = 0;
    int           last_pop_cyc = 0;
    logic [W-1:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every consumer handshake against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && rd_pvld && rd_prdy) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got %h expected none", rd_pd);
                end else begin
                    check("rd_pd", rd_pd, exp_q.pop_front());
                end
                n_pop++;
                last_pop_cyc = cyc;
            end
        end
    end

    // Protocol watcher: ore only after re, no read of an empty RAM, address order.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (ram_ore || prev_re) check("ore_after_re", ram_ore, prev_re);
                if (ram_re) begin
                    check("re_nonempty", tb_ram_cnt != 0, 1'b1);
                    check("ram_ra", ram_ra, tb_ra);
                end
                if (ram_we) check("ram_wa", ram_wa, tb_wa);
            end
        end
    end

    task automatic write_word(input logic [W-1:0] d, input bit expect_out, output int acc_cyc);
        int b;
        @(negedge clk);
        wr_pvld = 1'b1;
        wr_pd   = d;
        #1;
        b = 0;
        while (!wr_prdy && b < 50) begin
            @(negedge clk);
            #1;
            b++;
        end
        acc_cyc = cyc;
        if (!wr_prdy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL write_timeout: got wr_prdy=0 expected 1 for %h", d);
        end else if (expect_out) begin
            exp_q.push_back(d);
        end
    endtask

    task automatic idle_wr();
        @(negedge clk);
        wr_pvld = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < budget) begin
            @(negedge clk);
            b++;
        end
        check("drain", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        int  a0, a1, pops0;
        bit  wr_done;
        rst_n   = 1'b0;
        wr_pvld = 1'b0;
        wr_pd   = '0;
        rd_prdy = 1'b1;
        pwrbus  = 32'hDEAD_BEEF;
        #12;
        check("rst_rd_pvld", rd_pvld, 1'b0);
        check("rst_wr_prdy", wr_prdy, 1'b1);
        check("rst_fifo_count", fifo_count, 3'd0);
        check("rst_ram_re", ram_re, 1'b0);
        check("rst_ram_ore", ram_ore, 1'b0);
        check("rst_ram_we", ram_we, 1'b0);
        check("pwrbus", ram_pwrbus, 32'hDEAD_BEEF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

`ifndef NV_RAM_FIFO_CTRL_BYPASS_EN
        // Latency through the RAM from an empty FIFO.
        @(negedge clk);
        wr_pvld = 1'b1;
        wr_pd   = 64'hA5A5_0000_0000_0001;
        exp_q.push_back(64'hA5A5_0000_0000_0001);
        #1;
        check("lat_c0_we", ram_we, 1'b1);
        check("lat_c0_wa", ram_wa, 2'd0);
        @(negedge clk);
        wr_pvld = 1'b0;
        #1;
        check("lat_c1_re", ram_re, 1'b1);
        check("lat_c1_ra", ram_ra, 2'd0);
        check("lat_c1_ore", ram_ore, 1'b0);
        @(negedge clk);
        #1;
        check("lat_c2_ore", ram_ore, 1'b1);
        check("lat_c2_re", ram_re, 1'b0);
        @(negedge clk);
        #1;
        check("lat_c3_pvld", rd_pvld, 1'b0);
        check("lat_c3_count", fifo_count, 3'd1);
        @(negedge clk);
        #1;
        check("lat_c4_pvld", rd_pvld, 1'b1);
        @(negedge clk);
        #1;
        check("lat_c5_count", fifo_count, 3'd0);
        wait_drain(20);
`else
        // Bypass: straight into the output buffer, RAM untouched.
        @(negedge clk);
        wr_pvld = 1'b1;
        wr_pd   = 64'h2;
        exp_q.push_back(64'h2);
        #1;
        check("byp_c0_we", ram_we, 1'b0);
        @(negedge clk);
        wr_pvld = 1'b0;
        #1;
        check("byp_c1_pvld", rd_pvld, 1'b1);
        check("byp_c1_pd", rd_pd, 64'h2);
        check("byp_c1_re", ram_re, 1'b0);
        wait_drain(20);
`endif

        // Fill to capacity with the consumer stalled.
        @(negedge clk);
        rd_prdy = 1'b0;
        for (int d = 1; d <= 7; d++) write_word(64'(d), 1'b1, a0);
        @(negedge clk);
        wr_pd = 64'd8;
        #1;
        check("full_wr_prdy", wr_prdy, 1'b0);
        check("full_count", fifo_count, 3'd7);
        repeat (4) @(negedge clk);
        #1;
        check("full_hold_wr_prdy", wr_prdy, 1'b0);
        check("full_hold_count", fifo_count, 3'd7);
        @(negedge clk);
        wr_pvld = 1'b0;
        rd_prdy = 1'b1;
        wait_drain(40);
        check("full_empty_count", fifo_count, 3'd0);

        // Streaming at full rate.
        write_word(64'h100, 1'b1, a0);
        for (int d = 1; d < 16; d++) write_word(64'h100 + 64'(d), 1'b1, a1);
        idle_wr();
        wait_drain(40);
        check("stream_no_stall", a1 - a0, 15);
`ifndef NV_RAM_FIFO_CTRL_BYPASS_EN
        check("stream_last_pop", last_pop_cyc - a0, 19);
`endif

        // Consumer toggling ready every cycle.
        pops0   = n_pop;
        wr_done = 1'b0;
        fork
            begin
                int ac;
                for (int i = 0; i < 10; i++) write_word(64'h200 + 64'(i), 1'b1, ac);
                idle_wr();
                wr_done = 1'b1;
            end
            begin
                int b;
                b = 0;
                while ((!wr_done || exp_q.size() != 0) && b < 200) begin
                    @(negedge clk);
                    rd_prdy = ~rd_prdy;
                    b++;
                end
            end
        join
        @(negedge clk);
        rd_prdy = 1'b1;
        wait_drain(20);
        check("toggle_pops", n_pop - pops0, 10);

        // Asynchronous reset with words held.
        @(negedge clk);
        rd_prdy = 1'b0;
        for (int i = 0; i < 5; i++) write_word(64'h300 + 64'(i), 1'b0, a0);
        idle_wr();
        #1;
        check("pre_rst_count", fifo_count, 3'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rd_pvld", rd_pvld, 1'b0);
        check("arst_ram_ore", ram_ore, 1'b0);
        check("arst_count", fifo_count, 3'd0);
        check("arst_wr_prdy", wr_prdy, 1'b1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        rd_prdy = 1'b1;
        write_word(64'h1, 1'b1, a0);
        idle_wr();
        wait_drain(20);
        check("post_rst_count", fifo_count, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nv_ram_rwsp_4x64_fifo_ctrl.md
Name: nv_ram_rwsp_4x64_fifo_ctrl

Overview:
- Valid/ready FIFO controller that sits directly upstream of the 4x64 registered-read single-port-pair RAM (nv_ram_rwsp_4x64). It drives the RAM's write and read ports and consumes its 2-stage read output.
- Write side: converts a producer's valid/ready stream into RAM writes.
- Read side: schedules RAM reads (re, then ore one cycle later) and lands data in a small output buffer, so the consumer sees an ordinary valid/ready stream at full throughput.

Parameters:
- WIDTH, 64, data width; must equal the RAM width.
- RAM_DEPTH, 4, RAM entries; address width is 2.
- OUT_DEPTH, 3, output buffer entries; 3 is the minimum that sustains 1 word/cycle.

Ports:
- nvdla_core_clk  in  1  clock
- nvdla_core_rstn  in  1  async active-low reset
- wr_pvld  in  1  producer valid
- wr_prdy  out  1  producer ready
- wr_pd  in  WIDTH  producer data
- rd_pvld  out  1  consumer valid
- rd_prdy  in  1  consumer ready
- rd_pd  out  WIDTH  consumer data
- ram_we  out  1  RAM write enable
- ram_wa  out  2  RAM write address
- ram_di  out  WIDTH  RAM write data
- ram_re  out  1  RAM read-address latch enable
- ram_ra  out  2  RAM read address
- ram_ore  out  1  RAM output-register enable
- ram_dout  in  WIDTH  RAM read data
- pwrbus_ram_pd  in  32  power bus; forwarded combinationally
- ram_pwrbus_ram_pd  out  32  to RAM
- fifo_count  out  3  total words held (0..7)

Behaviour:
- Interface (already decided): one clock, nvdla_core_clk. Reset nvdla_core_rstn is asynchronous, active-low.
- Reset values:
  - wr_adr, rd_adr, ram_cnt (0..4), p1, p2, out_cnt, out pointers all 0.
  - rd_pvld=0, ram_re=0, ram_ore=0, ram_we=0, fifo_count=0, wr_prdy=1.
  - RAM contents are not cleared.
- Write path:
  - wr_prdy = (ram_cnt < RAM_DEPTH).
  - On wr_pvld & wr_prdy: ram_we=1, ram_wa=wr_adr, ram_di=wr_pd (all combinational). wr_adr increments mod 4.
- Read issue:
  - pop = rd_pvld & rd_prdy.
  - ram_re=1 when ram_cnt>0 and (out_cnt + p1 + p2 - pop) < OUT_DEPTH.
  - On issue: ram_ra=rd_adr, rd_adr increments mod 4, p1 is set next cycle.
  - A word written at edge N is readable by an issue in cycle N+1. The RAM reads M[ra_d] combinationally, so no forwarding is needed.
- Read pipeline:
  - p1 register = ram_re delayed one cycle; ram_ore = p1.
  - p2 register = p1 delayed one cycle.
  - In a cycle with p2=1, ram_dout is pushed into the output buffer at that cycle's edge.
  - ram_ore is never asserted except the cycle after ram_re, so the RAM output register holds otherwise.
- Counters:
  - ram_cnt += write, -= issue. A simultaneous write and issue leaves it unchanged.
  - out_cnt += p2, -= pop.
  - fifo_count = ram_cnt + p1 + p2 + out_cnt.
- Output buffer:
  - Circular, OUT_DEPTH entries.
  - rd_pvld = (out_cnt != 0); rd_pd = head entry.
  - rd_pd holds stable while rd_pvld & !rd_prdy.
  - Overflow is impossible by construction of the credit rule.
- Latency, write to empty FIFO at cycle 0:
  - cycle 1: ram_re, ra=0.
  - cycle 2: ram_ore.
  - cycle 3: p2 capture.
  - cycle 4: rd_pvld=1.
- Wrap-around: pointers wrap 3->0 independently. Full vs empty is decided by ram_cnt, not by pointer compare.
- Full: with rd_prdy=0, the FIFO holds 7 words (4 in RAM + 3 in the buffer) and wr_prdy=0.
- Reset mid-operation: all in-flight and buffered words are discarded immediately (async). ram_ore drops with p1.

Optional Feature:
- Macro NV_RAM_FIFO_CTRL_BYPASS_EN.
- Defined: when ram_cnt==0, p1==0, p2==0 and (out_cnt - pop) < OUT_DEPTH, an accepted write goes straight into the output buffer. ram_we=0 for that write and ram_cnt is unchanged. Write at cycle 0 gives rd_pvld at cycle 1. Ordering is preserved because bypass requires an empty RAM and an empty pipeline.
- Undefined: all writes go through the RAM; 4-cycle latency.

Decomposition:
- Shared package: WIDTH, RAM_DEPTH, address width, OUT_DEPTH, count width (3).
- Sub-module: nv_ram_fifo_obuf, the OUT_DEPTH-entry circular output buffer with push/pop and count.

Test Plan:
1. Bypass off: write 0xA5A5_0000_0000_0001 to empty at cycle 0 -> ram_re/ra=0 at cycle 1, ram_ore at cycle 2, rd_pvld with that data at cycle 4, fifo_count returns to 0 after pop.
2. rd_prdy=0, wr_pvld held with data 1..8 -> exactly 7 accepted, wr_prdy=0 after the 7th, fifo_count=7. Then release rd_prdy -> output 1..7 in order.
3. Continuous write and rd_prdy=1 for data 0..15 -> after initial latency, one word/cycle out in order. ram_re is never high with ram_cnt=0.
4. rd_prdy toggling 1,0,1,0 with 10 words -> no loss or duplication. ram_ore is high only the cycle after each ram_re. Addresses wrap 3->0 twice.
5. Reset asserted with 5 words held -> rd_pvld, ram_ore and fifo_count are 0 asynchronously. After release, writing 0x1 reads back 0x1 first.
6. NV_RAM_FIFO_CTRL_BYPASS_EN defined, write 0x2 to empty -> ram_we stays 0, rd_pvld=1 at cycle 1 with 0x2.
